// File: rtl/mips_loader_pkg.sv
// Shared types and sizing for the MIPS program loader, its interface and the core top.
package mips_loader_pkg;

  localparam int IMEM_DEPTH = 1024;
  localparam int INST_W     = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Valid/ready instruction-word stream feeding the program loader.
interface inst_mem_loader_if #(
  parameter int DATA_W = mips_loader_pkg::INST_W
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

// File: rtl/inst_mem_loader.sv
// Program loader: clears the instruction memory, streams a program into it and
// releases the MIPS core from reset once the final word has landed.
module inst_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  inst_mem_loader_if.slave  ld,
  output logic [DATA_W-1:0] instMem [DEPTH],
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              xfer;

  assign xfer = ld.in_valid && (state_q == LOAD);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          mem_we    = 1'b1;
          mem_wdata = ld.in_data;
          ptr_d     = ptr_q + 1'b1;
          cnt_d     = cnt_q + 1'b1;
          // Last word wins over overflow: a full-depth program ending on in_last is legal.
          if (ld.in_last) begin
            state_d = RUN;
          end else if (ptr_q == PTR_LAST) begin
            state_d = ERR;
            ptr_d   = ptr_q;
          end
        end
      end
      RUN, ERR: begin
        if (start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory contents survive rst; only the write strobe is suppressed while it is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (mem_we) instMem[ptr_q] <= mem_wdata;
    end
  end

  assign ld.in_ready = (state_q == LOAD);
  assign cpu_rst     = (state_q != RUN);
  assign done        = (state_q == RUN);
  assign err         = (state_q == ERR);
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader against an array/queue reference model.
module tb_inst_mem_loader;
  import mips_loader_pkg::*;

  localparam int DEPTH  = IMEM_DEPTH;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cnt;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [31:0]     inst_mem [DEPTH];
  logic            cpu_rst, done, err;
  logic [ADDR_W:0] word_count;

  inst_mem_loader_if #(.DATA_W(INST_W)) ld ();

  inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(INST_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ld         (ld),
    .instMem    (inst_mem),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  int          ref_cnt = 0;
  exp_t        exp_q [$];
  bit          pend = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every accepted beat must show up in memory and in word_count one edge later.
  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: word %h accepted with no expectation", ld.in_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("beat_data", inst_mem[e.addr], e.data);
        chk("beat_count", 32'(word_count), e.cnt);
      end
    end
    pend = ld.in_valid && ld.in_ready && !rst;
  end

  task automatic check_image(input string nm);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (inst_mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d words differ, first at %0d actual=%h required=%h",
               nm, bad, first, inst_mem[first], ref_mem[first]);
    end
  endtask

  task automatic do_start();
    int n = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_cpu_rst", cpu_rst, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    while (!ld.in_ready && n < 2 * DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clear_cycles", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_cnt = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int gap);
    bit rdy;
    int n = 0;
    ld.in_valid = 1'b1;
    ld.in_data  = d;
    ld.in_last  = last;
    exp_q.push_back('{addr: ref_cnt, data: d, cnt: ref_cnt + 1});
    ref_mem[ref_cnt] = d;
    ref_cnt++;
    do begin
      rdy = ld.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 64);
    if (!rdy) chk("beat_timeout", 0, 1);
    ld.in_valid = 1'b0;
    ld.in_last  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_run(input int cnt);
    chk("run_done", done, 1);
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_in_ready", ld.in_ready, 0);
    chk("run_err", err, 0);
    chk("run_word_count", 32'(word_count), cnt);
  endtask

  logic [31:0] prog_a [3];

  initial begin
    int len;
    prog_a[0] = 32'h2008_0005;
    prog_a[1] = 32'h2009_0007;
    prog_a[2] = 32'h0109_5020;
    rst = 1'b1;
    start = 1'b0;
    ld.in_valid = 1'b0;
    ld.in_data  = '0;
    ld.in_last  = 1'b0;

    @(posedge clk); #1 rst = 1'b0;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_in_ready", ld.in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_word_count", 32'(word_count), 0);

    // Three-word program, valid every cycle
    do_start();
    for (int i = 0; i < 3; i++) send_word(prog_a[i], i == 2, 0);
    check_run(3);
    check_image("img_prog_a");

    // Same program with valid toggling, restarted from RUN
    do_start();
    for (int i = 0; i < 3; i++) send_word(prog_a[i], i == 2, (i < 2) ? 1 : 0);
    check_run(3);
    check_image("img_prog_a_gaps");

    // Random program with random bubbles
    do_start();
    len = $urandom_range(4, 40);
    for (int i = 0; i < len; i++) send_word($urandom, i == len - 1, $urandom_range(0, 2));
    check_run(len);
    check_image("img_random");

    // Overflow: full depth without in_last
    do_start();
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 1'b0, 0);
    chk("ovf_err", err, 1);
    chk("ovf_in_ready", ld.in_ready, 0);
    chk("ovf_cpu_rst", cpu_rst, 1);
    chk("ovf_done", done, 0);
    chk("ovf_word_count", 32'(word_count), DEPTH);
    check_image("img_overflow");
    repeat (3) begin
      ld.in_valid = 1'b1;
      ld.in_data  = $urandom;
      @(posedge clk); #1;
    end
    ld.in_valid = 1'b0;
    check_image("img_err_hold");
    do_start();
    send_word(32'h0800_0000, 1'b1, 0);
    check_run(1);

    // Reload from RUN with a one-word program
    do_start();
    send_word(32'h0800_0000, 1'b1, 0);
    check_run(1);
    check_image("img_one_word");

    // Reset mid-LOAD keeps the partial image; IDLE ignores in_valid
    do_start();
    send_word($urandom, 1'b0, 0);
    send_word($urandom, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_in_ready", ld.in_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_word_count", 32'(word_count), 0);
    check_image("img_mid_rst");
    for (int i = 0; i < 4; i++) begin
      ld.in_valid = i[0];
      ld.in_data  = $urandom;
      ld.in_last  = 1'b1;
      @(posedge clk); #1;
    end
    ld.in_valid = 1'b0;
    ld.in_last  = 1'b0;
    @(posedge clk); #1;
    check_image("img_idle_valid");
    chk("idle_done", done, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
